// File: rtl/instr_decode_pipe_pkg.sv
// dec_pkg: aluop codes, R opcode / I class ranges and the decoded bundle
// shared by instr_decode_comb and instr_decode_pipe.
package dec_pkg;

  localparam int DEC_IW   = 16;
  localparam int DEC_RW   = 3;
  localparam int DEC_IMMW = 8;
  localparam int DEC_AOPW = 5;
  localparam int DEC_OPCW = DEC_IW - 1 - 2 * DEC_RW;

  localparam logic [4:0] ALU_NOP       = 5'd0;
  localparam logic [4:0] ALU_ADD       = 5'd1;
  localparam logic [4:0] ALU_SUB       = 5'd2;
  localparam logic [4:0] ALU_AND       = 5'd3;
  localparam logic [4:0] ALU_OR        = 5'd4;
  localparam logic [4:0] ALU_XOR       = 5'd5;
  localparam logic [4:0] ALU_NOT       = 5'd6;
  localparam logic [4:0] ALU_MOV       = 5'd7;
  localparam logic [4:0] ALU_SAR       = 5'd8;
  localparam logic [4:0] ALU_SAL       = 5'd9;
  localparam logic [4:0] ALU_SHR       = 5'd10;
  localparam logic [4:0] ALU_SHL       = 5'd11;
  localparam logic [4:0] ALU_ROR       = 5'd12;
  localparam logic [4:0] ALU_ROL       = 5'd13;
  localparam logic [4:0] ALU_CMP       = 5'd14;
  localparam logic [4:0] ALU_TST       = 5'd15;
  localparam logic [4:0] ALU_MUL       = 5'd16;
  localparam logic [4:0] ALU_DIV       = 5'd17;
  localparam logic [4:0] ALU_MOD       = 5'd18;
  localparam logic [4:0] ALU_JZ        = 5'd19;
  localparam logic [4:0] ALU_JNZ       = 5'd20;
  localparam logic [4:0] ALU_JC        = 5'd21;
  localparam logic [4:0] ALU_JNC       = 5'd22;
  localparam logic [4:0] ALU_JN        = 5'd23;
  localparam logic [4:0] ALU_JMP       = 5'd24;
  localparam logic [4:0] ALU_LDI       = 5'd25;
  localparam logic [4:0] ALU_ADDI      = 5'd26;
  localparam logic [4:0] ALU_LD        = 5'd27;
  localparam logic [4:0] ALU_ST        = 5'd28;
  localparam logic [4:0] ALU_OUT       = 5'd29;
  localparam logic [4:0] ALU_SHOWDMSEG = 5'd30;

  localparam logic [DEC_OPCW-1:0] R_NOP = 9'h000;
  localparam logic [DEC_OPCW-1:0] R_NOT = 9'h006;
  localparam logic [DEC_OPCW-1:0] R_MOV = 9'h008;
  localparam logic [DEC_OPCW-1:0] R_TST = 9'h010;
  localparam logic [DEC_OPCW-1:0] R_MUL = 9'h012;
  localparam logic [DEC_OPCW-1:0] R_MOD = 9'h014;

  localparam logic [3:0] I_JZ        = 4'd0;
  localparam logic [3:0] I_JMP       = 4'd5;
  localparam logic [3:0] I_SHOWDMSEG = 4'd11;

  typedef struct packed {
    logic [DEC_RW-1:0]   op1;
    logic [DEC_RW-1:0]   op2;
    logic [DEC_AOPW-1:0] aluop;
    logic [DEC_IMMW-1:0] imm;
    logic                shift;
    logic                jump;
    logic                illegal;
  } dec_bundle_t;

endpackage

// File: rtl/instr_decode_pipe_if.sv
// Fetch-side and ALU-side handshake bundle of instr_decode_pipe.
// slave = decoder; master = fetch/consumer. DEC_PERF_CNT_EN adds counters.
interface instr_decode_pipe_if #(
  parameter int IW   = 16,
  parameter int RW   = 3,
  parameter int IMMW = 8,
  parameter int AOPW = 5
`ifdef DEC_PERF_CNT_EN
  , parameter int CNTW = 16
`endif
);
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   instr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [RW-1:0]   op1;
  logic [RW-1:0]   op2;
  logic [AOPW-1:0] aluop;
  logic [IMMW-1:0] immdata;
  logic            shiftflag;
  logic            is_jump;
  logic            illegal;
`ifdef DEC_PERF_CNT_EN
  logic [CNTW-1:0] instr_cnt;
  logic [CNTW-1:0] illegal_cnt;
`endif

  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, op1, op2, aluop,
    output immdata, shiftflag, is_jump, illegal
`ifdef DEC_PERF_CNT_EN
    , output instr_cnt, illegal_cnt
`endif
  );

  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, op1, op2, aluop,
    input  immdata, shiftflag, is_jump, illegal
`ifdef DEC_PERF_CNT_EN
    , input instr_cnt, illegal_cnt
`endif
  );

endinterface

// File: rtl/instr_decode_pipe_comb.sv
// instr_decode_comb: pure combinational instr -> dec_bundle_t lookup.
// Ports: instr_i (instruction word), bundle_o (decoded fields).
module instr_decode_comb
  import dec_pkg::*;
#(
  parameter int IW   = 16,
  parameter int RW   = 3,
  parameter int IMMW = 8
) (
  input  logic [IW-1:0] instr_i,
  output dec_bundle_t   bundle_o
);

  logic [DEC_OPCW-1:0] opc;
  logic [3:0]          cls;
  logic [DEC_RW-1:0]   op1;
  logic [DEC_RW-1:0]   op2;
  logic [DEC_IMMW-1:0] imm;
  logic [4:0]          aop;
  logic                bad;

  always_comb begin
    opc      = instr_i[IW-2:2*RW];
    cls      = instr_i[IW-2:IW-5];
    op1      = '0;
    op2      = '0;
    imm      = '0;
    aop      = ALU_NOP;
    bad      = 1'b0;
    bundle_o = '0;
    if (!instr_i[IW-1]) begin
      op1 = instr_i[2*RW-1:RW];
      op2 = instr_i[RW-1:0];
      unique case (1'b1)
        (opc <= R_NOT):
          aop = 5'(opc - R_NOP);
        (opc >= R_MOV && opc <= R_TST):
          aop = ALU_MOV + 5'(opc - R_MOV);
        (opc >= R_MUL && opc <= R_MOD):
          aop = ALU_MUL + 5'(opc - R_MUL);
        default:
          bad = 1'b1;
      endcase
    end else begin
      op1 = instr_i[IW-6 -: RW];
      imm = instr_i[IMMW-1:0];
      if (cls <= I_SHOWDMSEG) begin
        aop = ALU_JZ + 5'(cls - I_JZ);
      end else begin
        bad = 1'b1;
      end
    end
    // Illegal words travel downstream with every field cleared.
    if (bad) begin
      bundle_o.illegal = 1'b1;
    end else begin
      bundle_o.op1   = op1;
      bundle_o.op2   = op2;
      bundle_o.imm   = imm;
      bundle_o.aluop = aop;
      bundle_o.shift = (aop >= ALU_SAR) && (aop <= ALU_ROL);
      bundle_o.jump  = (aop >= ALU_JZ) && (aop <= ALU_JMP);
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: registered decoder, valid/ready both sides, flush.
// Ports: clk, rst_n (sync, active low), bus (slave); DEC_PERF_CNT_EN adds counters.
module instr_decode_pipe
  import dec_pkg::*;
#(
  parameter int IW   = 16,
  parameter int RW   = 3,
  parameter int IMMW = 8,
  parameter int AOPW = 5
`ifdef DEC_PERF_CNT_EN
  , parameter int CNTW = 16
`endif
) (
  input logic               clk,
  input logic               rst_n,
  instr_decode_pipe_if.slave bus
);

  dec_bundle_t dec;
  dec_bundle_t bun_q;
  dec_bundle_t bun_d;
  logic        valid_q;
  logic        valid_d;
  logic        in_ready;
  logic        accept;

  instr_decode_comb #(
    .IW   (IW),
    .RW   (RW),
    .IMMW (IMMW)
  ) u_comb (
    .instr_i  (bus.instr),
    .bundle_o (dec)
  );

  assign in_ready = !valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;

  // Flush beats accept; a held bundle stays untouched under back-pressure.
  always_comb begin
    valid_d = valid_q;
    bun_d   = bun_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      bun_d   = dec;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

`ifdef DEC_PERF_CNT_EN
  logic [CNTW-1:0] icnt_q;
  logic [CNTW-1:0] icnt_d;
  logic [CNTW-1:0] lcnt_q;
  logic [CNTW-1:0] lcnt_d;

  always_comb begin
    icnt_d = icnt_q;
    lcnt_d = lcnt_q;
    if (accept && !bus.flush) begin
      if (icnt_q != '1) begin
        icnt_d = icnt_q + CNTW'(1);
      end
      if (dec.illegal && lcnt_q != '1) begin
        lcnt_d = lcnt_q + CNTW'(1);
      end
    end
  end

  assign bus.instr_cnt   = icnt_q;
  assign bus.illegal_cnt = lcnt_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      bun_q   <= '0;
`ifdef DEC_PERF_CNT_EN
      icnt_q  <= '0;
      lcnt_q  <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      bun_q   <= bun_d;
`ifdef DEC_PERF_CNT_EN
      icnt_q  <= icnt_d;
      lcnt_q  <= lcnt_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.op1       = RW'(bun_q.op1);
  assign bus.op2       = RW'(bun_q.op2);
  assign bus.aluop     = AOPW'(bun_q.aluop);
  assign bus.immdata   = IMMW'(bun_q.imm);
  assign bus.shiftflag = bun_q.shift;
  assign bus.is_jump   = bun_q.jump;
  assign bus.illegal   = bun_q.illegal;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Bench for instr_decode_pipe: scoreboard of expected bundles plus
// per-scenario inline checks; define DEC_PERF_CNT_EN to cover counters.
module tb_instr_decode_pipe;

`ifdef DEC_PERF_CNT_EN
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;
`endif

  typedef struct packed {
    logic [2:0] op1;
    logic [2:0] op2;
    logic [4:0] aluop;
    logic [7:0] imm;
    logic       sh;
    logic       jmp;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   delivered;
  bit   mvalid;
  exp_t sbq[$];
`ifdef DEC_PERF_CNT_EN
  int   mcnt;
  int   mill;
`endif

  instr_decode_pipe_if #(
    .IW(16), .RW(3), .IMMW(8), .AOPW(5)
`ifdef DEC_PERF_CNT_EN
    , .CNTW(CNTW)
`endif
  ) bus ();

  instr_decode_pipe #(
    .IW(16), .RW(3), .IMMW(8), .AOPW(5)
`ifdef DEC_PERF_CNT_EN
    , .CNTW(CNTW)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t exp_decode(input logic [15:0] w);
    exp_t e;
    int   code;
    int   a;
    e = '0;
    a = -1;
    if (!w[15]) begin
      code = int'(w[14:6]);
      if (code <= 6) a = code;
      else if (code >= 8 && code <= 16) a = code - 1;
      else if (code >= 18 && code <= 20) a = code - 2;
      if (a >= 0) begin
        e.op1 = w[5:3];
        e.op2 = w[2:0];
      end
    end else begin
      code = int'(w[14:11]);
      if (code < 12) begin
        a     = 19 + code;
        e.op1 = w[10:8];
        e.imm = w[7:0];
      end
    end
    if (a < 0) begin
      e.ill = 1'b1;
    end else begin
      e.aluop = 5'(a);
      e.sh    = (a >= 8 && a <= 13);
      e.jmp   = (a >= 19 && a <= 24);
    end
    return e;
  endfunction

  // Scoreboard: compare every bundle the consumer actually takes.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready && !bus.flush) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got bundle aluop=%0d, required none", bus.aluop);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        delivered++;
        if ({bus.op1, bus.op2, bus.aluop, bus.immdata,
             bus.shiftflag, bus.is_jump, bus.illegal} !== e) begin
          errors++;
          $display("FAIL sb_bundle: got op1=%0d op2=%0d aluop=%0d imm=%0h sh=%0b j=%0b ill=%0b, required op1=%0d op2=%0d aluop=%0d imm=%0h sh=%0b j=%0b ill=%0b",
                   bus.op1, bus.op2, bus.aluop, bus.immdata, bus.shiftflag,
                   bus.is_jump, bus.illegal, e.op1, e.op2, e.aluop, e.imm,
                   e.sh, e.jmp, e.ill);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [15:0] w,
                       input logic fl, input logic r);
    bus.in_valid  = v;
    bus.instr     = w;
    bus.flush     = fl;
    bus.out_ready = r;
  endtask

  task automatic tick();
    logic        v, fl, r, acc;
    logic [15:0] w;
    exp_t        e;
    v   = bus.in_valid;
    fl  = bus.flush;
    r   = bus.out_ready;
    w   = bus.instr;
    acc = v && (!mvalid || r);
    e   = exp_decode(w);
    @(posedge clk);
    #1;
    if (fl) begin
      if (mvalid && sbq.size() > 0) void'(sbq.pop_front());
      mvalid = 1'b0;
    end else if (acc) begin
      sbq.push_back(e);
      mvalid = 1'b1;
`ifdef DEC_PERF_CNT_EN
      if (mcnt < CMAX) mcnt++;
      if (e.ill && mill < CMAX) mill++;
`endif
    end else if (r) begin
      mvalid = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 16'hAD5A, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    sbq.delete();
    mvalid = 1'b0;
`ifdef DEC_PERF_CNT_EN
    mcnt = 0;
    mill = 0;
`endif
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b required=0", bus.out_valid); end
    checks++; if ({bus.op1, bus.op2, bus.aluop, bus.immdata, bus.shiftflag, bus.is_jump, bus.illegal} !== 22'd0) begin
      errors++; $display("FAIL rst_fields got=%0h required=0", {bus.op1, bus.op2, bus.aluop, bus.immdata, bus.shiftflag, bus.is_jump, bus.illegal});
    end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%0b required=1", bus.in_ready); end
`ifdef DEC_PERF_CNT_EN
    checks++; if (bus.instr_cnt !== '0 || bus.illegal_cnt !== '0) begin
      errors++; $display("FAIL rst_cnt got=%0d/%0d required=0/0", bus.instr_cnt, bus.illegal_cnt);
    end
`endif
    rst_n = 1'b1;
    drive(1'b1, 16'h0053, 1'b0, 1'b0);
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_pre_rst got=%0b required=1", bus.out_valid); end
    rst_n = 1'b0;
    drive(1'b1, 16'hAD5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    sbq.delete();
    mvalid = 1'b0;
`ifdef DEC_PERF_CNT_EN
    mcnt = 0;
    mill = 0;
`endif
    checks++; if (bus.out_valid !== 1'b0 || bus.aluop !== 5'd0) begin
      errors++; $display("FAIL rst_drops_held got valid=%0b aluop=%0d required 0/0", bus.out_valid, bus.aluop);
    end
    rst_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_valid got=%0b required=0", bus.out_valid); end
  endtask

  task automatic test_r_add();
    drive(1'b1, 16'h0053, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL add_in_ready got=%0b required=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b required=1", bus.out_valid); end
    checks++; if (bus.aluop !== 5'd1) begin errors++; $display("FAIL add_aluop got=%0d required=1", bus.aluop); end
    checks++; if (bus.op1 !== 3'd2 || bus.op2 !== 3'd3) begin errors++; $display("FAIL add_ops got=%0d,%0d required=2,3", bus.op1, bus.op2); end
    checks++; if (bus.immdata !== 8'h00 || bus.shiftflag !== 1'b0) begin errors++; $display("FAIL add_imm_sh got=%0h,%0b required=0,0", bus.immdata, bus.shiftflag); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%0b required=0", bus.out_valid); end
  endtask

  task automatic test_i_jmp();
    drive(1'b1, 16'hAD5A, 1'b0, 1'b1);
    tick();
    checks++; if (bus.aluop !== 5'd24 || bus.is_jump !== 1'b1) begin errors++; $display("FAIL jmp_op got aluop=%0d j=%0b required 24/1", bus.aluop, bus.is_jump); end
    checks++; if (bus.op1 !== 3'd5 || bus.op2 !== 3'd0) begin errors++; $display("FAIL jmp_ops got=%0d,%0d required=5,0", bus.op1, bus.op2); end
    checks++; if (bus.immdata !== 8'h5A) begin errors++; $display("FAIL jmp_imm got=%0h required=5a", bus.immdata); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_shift_illegal();
    drive(1'b1, 16'h0240, 1'b0, 1'b1);
    tick();
    checks++; if (bus.aluop !== 5'd8 || bus.shiftflag !== 1'b1) begin errors++; $display("FAIL sar got aluop=%0d sh=%0b required 8/1", bus.aluop, bus.shiftflag); end
    drive(1'b1, 16'h01C0, 1'b0, 1'b1);
    tick();
    checks++; if (bus.illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got=%0b required=1", bus.illegal); end
    checks++; if ({bus.op1, bus.op2, bus.aluop, bus.immdata, bus.shiftflag, bus.is_jump} !== 21'd0) begin
      errors++; $display("FAIL ill_fields got=%0h required=0", {bus.op1, bus.op2, bus.aluop, bus.immdata, bus.shiftflag, bus.is_jump});
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got=%0b required=1", bus.out_valid); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_decode_table();
    logic [15:0] tbl[16];
    int n0;
    tbl = '{16'h0000, 16'h0180, 16'h01FF, 16'h0200, 16'h0340, 16'h0380,
            16'h0400, 16'h0440, 16'h0480, 16'h0500, 16'h0540, 16'h7FFF,
            16'h8000, 16'hD8FF, 16'hE123, 16'hFFFF};
    n0 = delivered;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, tbl[i], 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (delivered - n0 !== 16) begin errors++; $display("FAIL table_count got=%0d required=16", delivered - n0); end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 16'h0053, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0240, 1'b0, 1'b0);
      #1;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%0b required=0", i, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b1 || bus.aluop !== 5'd1 || bus.op1 !== 3'd2 || bus.op2 !== 3'd3) begin
        errors++; $display("FAIL bp_stable[%0d] got v=%0b aluop=%0d op1=%0d op2=%0d required 1/1/2/3", i, bus.out_valid, bus.aluop, bus.op1, bus.op2);
      end
      tick();
    end
    drive(1'b1, 16'h0240, 1'b0, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got=%0b required=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.aluop !== 5'd8) begin errors++; $display("FAIL bp_next got v=%0b aluop=%0d required 1/8", bus.out_valid, bus.aluop); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    int n0;
    int bad_rdy;
    int bad_vld;
    n0 = delivered;
    bad_rdy = 0;
    bad_vld = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b1);
      #1;
      if (bus.in_ready !== 1'b1) bad_rdy++;
      tick();
      if (bus.out_valid !== 1'b1) bad_vld++;
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL b2b_in_ready stalls got=%0d required=0", bad_rdy); end
    checks++; if (bad_vld != 0) begin errors++; $display("FAIL b2b_valid gaps got=%0d required=0", bad_vld); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (delivered - n0 !== 8) begin errors++; $display("FAIL b2b_count got=%0d required=8", delivered - n0); end
  endtask

  task automatic test_flush();
    int n0;
    n0 = delivered;
    drive(1'b1, 16'h0053, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'hAD5A, 1'b1, 1'b0);
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_held got=%0b required=0", bus.out_valid); end
    drive(1'b1, 16'h0053, 1'b1, 1'b1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%0b required=1", bus.in_ready); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_incoming got=%0b required=0", bus.out_valid); end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (delivered !== n0) begin errors++; $display("FAIL flush_emitted got=%0d required=0", delivered - n0); end
`ifdef DEC_PERF_CNT_EN
    checks++; if (int'(bus.instr_cnt) !== mcnt) begin errors++; $display("FAIL flush_cnt got=%0d required=%0d", bus.instr_cnt, mcnt); end
`endif
  endtask

`ifdef DEC_PERF_CNT_EN
  task automatic test_counters();
    do_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, (i == 5 || i == 12) ? 16'h01C0 : 16'h0053, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    checks++; if (int'(bus.instr_cnt) !== CMAX) begin errors++; $display("FAIL cnt_sat got=%0d required=%0d", bus.instr_cnt, CMAX); end
    checks++; if (bus.illegal_cnt !== 4'd2) begin errors++; $display("FAIL cnt_illegal got=%0d required=2", bus.illegal_cnt); end
    do_reset();
    checks++; if (bus.instr_cnt !== 4'd0 || bus.illegal_cnt !== 4'd0) begin
      errors++; $display("FAIL cnt_reset got=%0d/%0d required=0/0", bus.instr_cnt, bus.illegal_cnt);
    end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    errors    = 0;
    checks    = 0;
    delivered = 0;
    mvalid    = 1'b0;
    rst_n     = 1'b0;
    drive(1'b0, 16'h0000, 1'b0, 1'b0);
    test_reset();
    test_r_add();
    test_i_jmp();
    test_shift_illegal();
    test_decode_table();
    test_backpressure();
    test_back_to_back();
    test_flush();
`ifdef DEC_PERF_CNT_EN
    test_counters();
`endif
    checks++; if (sbq.size() != 0) begin errors++; $display("FAIL sb_leftover got=%0d required=0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
